// File: rtl/seq_multiplier_hs.sv
// Sequential shift-add multiplier with valid/ready handshakes on both sides.
// Operands are reduced to magnitudes on accept; the sign is applied once at exit,
// so the accumulator only ever grows during the calculation.
module seq_multiplier_hs #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned SW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e          state_q;
    logic [PW-1:0]   ma_q;
    logic [PW-1:0]   acc_q;
    logic [WIDTH-1:0] mb_q;
    logic [SW-1:0]   step_q;
    logic            neg_q;

    logic [PW-1:0]    acc_next;
    logic [WIDTH-1:0] mb_next;
    logic [SW-1:0]    step_next;
    logic             calc_exit;
    logic [PW-1:0]    result;

    // Magnitude of a signed operand; the most-negative value maps to 2^(WIDTH-1),
    // which still fits as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        if (sgn && v[WIDTH-1]) begin
            return ~v + WIDTH'(1);
        end
        return v;
    endfunction

    // Handshake flags decode straight from the state register.
    assign in_ready = rst_n && (state_q == StIdle);
    assign busy     = (state_q == StCalc) || (state_q == StDone);

    // One shift-add step and the exit decision for the current CALC cycle.
    always_comb begin
        acc_next  = mb_q[0] ? (acc_q + ma_q) : acc_q;
        mb_next   = mb_q >> 1;
        step_next = step_q + SW'(1);
        calc_exit = (step_next == SW'(WIDTH)) || (EARLY_EXIT && (mb_next == '0));
        result    = neg_q ? (~acc_next + PW'(1)) : acc_next;
    end

    // Control FSM with registered datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ma_q        <= '0;
            mb_q        <= '0;
            acc_q       <= '0;
            step_q      <= '0;
            neg_q       <= 1'b0;
            out_valid   <= 1'b0;
            out_product <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        ma_q    <= {{WIDTH{1'b0}}, magnitude(in_a, in_signed)};
                        mb_q    <= magnitude(in_b, in_signed);
                        neg_q   <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                        acc_q   <= '0;
                        step_q  <= '0;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q  <= acc_next;
                    ma_q   <= ma_q << 1;
                    mb_q   <= mb_next;
                    step_q <= step_next;
                    if (calc_exit) begin
                        out_product <= result;
                        out_valid   <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_hs.sv
// Directed bench for seq_multiplier_hs: instance 0 runs the full WIDTH steps,
// instance 1 uses early exit. Expected products and latencies are hand-computed.
module tb_seq_multiplier_hs;

    logic        clk;
    logic        rst_n;
    logic [1:0]  in_valid_s;
    logic [1:0]  in_ready_s;
    logic [7:0]  in_a_s [2];
    logic [7:0]  in_b_s [2];
    logic [1:0]  in_signed_s;
    logic [1:0]  out_valid_s;
    logic [1:0]  out_ready_s;
    logic [15:0] out_product_s [2];
    logic [1:0]  busy_s;

    int n_vec;
    int n_err;

    seq_multiplier_hs #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_full (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid_s[0]),
        .in_ready   (in_ready_s[0]),
        .in_a       (in_a_s[0]),
        .in_b       (in_b_s[0]),
        .in_signed  (in_signed_s[0]),
        .out_valid  (out_valid_s[0]),
        .out_ready  (out_ready_s[0]),
        .out_product(out_product_s[0]),
        .busy       (busy_s[0])
    );

    seq_multiplier_hs #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_early (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid_s[1]),
        .in_ready   (in_ready_s[1]),
        .in_a       (in_a_s[1]),
        .in_b       (in_b_s[1]),
        .in_signed  (in_signed_s[1]),
        .out_valid  (out_valid_s[1]),
        .out_ready  (out_ready_s[1]),
        .out_product(out_product_s[1]),
        .busy       (busy_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid on instance d, returning cycles since the accept edge.
    task automatic wait_result(input int d, output int lat);
        lat = 0;
        while (out_valid_s[d] !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Full transaction with out_ready held high; checks latency, product, 1-cycle pulse.
    task automatic run_op(input int d, input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic sgn,
                          input logic [15:0] exp_p, input int exp_lat);
        int lat;
        out_ready_s[d] = 1'b1;
        check({tag, "_in_ready"}, {31'd0, in_ready_s[d]}, 32'd1);
        in_valid_s[d]  = 1'b1;
        in_a_s[d]      = a;
        in_b_s[d]      = b;
        in_signed_s[d] = sgn;
        tick();
        in_valid_s[d] = 1'b0;
        in_a_s[d]     = 8'h00;
        in_b_s[d]     = 8'h00;
        wait_result(d, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_prod"}, {16'd0, out_product_s[d]}, {16'd0, exp_p});
        tick();
        check({tag, "_pulse"}, {31'd0, out_valid_s[d]}, 32'd0);
    endtask

    initial begin
        int lat;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid_s  = '0;
        in_signed_s = '0;
        out_ready_s = 2'b11;
        for (int i = 0; i < 2; i++) begin
            in_a_s[i] = '0;
            in_b_s[i] = '0;
        end

        #12;
        check("rst_out_valid", {30'd0, out_valid_s}, 32'd0);
        check("rst_busy", {30'd0, busy_s}, 32'd0);
        check("rst_product", {out_product_s[1], out_product_s[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", {30'd0, in_ready_s}, 32'd3);

        // Full-length instance.
        run_op(0, "u255x255", 8'd255, 8'd255, 1'b0, 16'hFE01, 8);
        run_op(0, "s_m128x_m128", 8'h80, 8'h80, 1'b1, 16'h4000, 8);
        run_op(0, "s_m3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 8);
        run_op(0, "s127x_m128", 8'h7F, 8'h80, 1'b1, 16'hC080, 8);
        run_op(0, "u80x80", 8'h80, 8'h80, 1'b0, 16'h4000, 8);

        // Early-exit instance.
        run_op(1, "ee13x0", 8'd13, 8'd0, 1'b0, 16'd0, 1);
        run_op(1, "ee200x3", 8'd200, 8'd3, 1'b0, 16'h0258, 2);
        run_op(1, "ee1x128", 8'd1, 8'd128, 1'b0, 16'd128, 8);
        run_op(1, "ee_s_m3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 3);

        // Backpressure: result held while the consumer stalls.
        out_ready_s[0] = 1'b0;
        in_valid_s[0]  = 1'b1;
        in_a_s[0]      = 8'd12;
        in_b_s[0]      = 8'd11;
        in_signed_s[0] = 1'b0;
        tick();
        in_valid_s[0] = 1'b0;
        wait_result(0, lat);
        check("bp_lat", lat, 8);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, out_valid_s[0]}, 32'd1);
            check("bp_prod", {16'd0, out_product_s[0]}, 32'd132);
            check("bp_in_ready", {31'd0, in_ready_s[0]}, 32'd0);
            check("bp_busy", {31'd0, busy_s[0]}, 32'd1);
            tick();
        end
        out_ready_s[0] = 1'b1;
        tick();
        check("bp_release_valid", {31'd0, out_valid_s[0]}, 32'd0);
        check("bp_release_in_ready", {31'd0, in_ready_s[0]}, 32'd1);

        // Back-to-back: in_valid stays high, operands change after the first accept.
        in_valid_s[0]  = 1'b1;
        in_a_s[0]      = 8'd6;
        in_b_s[0]      = 8'd7;
        tick();
        check("b2b_first_busy", {31'd0, busy_s[0]}, 32'd1);
        in_a_s[0] = 8'd9;
        in_b_s[0] = 8'd9;
        wait_result(0, lat);
        check("b2b_first_lat", lat, 8);
        check("b2b_first_prod", {16'd0, out_product_s[0]}, 32'd42);
        tick();
        check("b2b_idle_in_ready", {31'd0, in_ready_s[0]}, 32'd1);
        check("b2b_idle_valid", {31'd0, out_valid_s[0]}, 32'd0);
        tick();
        check("b2b_second_accept", {31'd0, busy_s[0]}, 32'd1);
        in_valid_s[0] = 1'b0;
        tick();
        tick();
        tick();
        check("b2b_hold_prod", {16'd0, out_product_s[0]}, 32'd42);
        wait_result(0, lat);
        check("b2b_second_lat", lat + 3, 8);
        check("b2b_second_prod", {16'd0, out_product_s[0]}, 32'd81);
        tick();

        // Asynchronous reset in the middle of a calculation.
        in_valid_s[0] = 1'b1;
        in_a_s[0]     = 8'd50;
        in_b_s[0]     = 8'd3;
        tick();
        in_valid_s[0] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("ar_busy_before", {31'd0, busy_s[0]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, out_valid_s[0]}, 32'd0);
        check("ar_busy", {31'd0, busy_s[0]}, 32'd0);
        check("ar_prod", {16'd0, out_product_s[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op(0, "ar_10x10", 8'd10, 8'd10, 1'b0, 16'd100, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_multiplier_hs.md
Name: seq_multiplier_hs

Overview:
Parametrised sequential shift-add multiplier with valid/ready handshakes on both input and output. Supports unsigned and two's-complement signed operands, selected per transaction, and optional early termination. It is the general-width successor of the team's fixed 8-bit multiplier. It sits between an operand producer and a result consumer that can each stall independently.

Parameters:
WIDTH, 8, operand width in bits (>= 2); product is 2*WIDTH bits.
EARLY_EXIT, 0, 1 = end the computation as soon as no set multiplier bits remain.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous reset, active-low
in_valid  input  1  operand request
in_ready  output  1  block can accept operands
in_a  input  WIDTH  multiplicand
in_b  input  WIDTH  multiplier
in_signed  input  1  1 = treat in_a/in_b as two's complement; sampled with operands
out_valid  output  1  out_product holds a new result
out_ready  input  1  consumer accepts result
out_product  output  2*WIDTH  product (two's complement when signed)
busy  output  1  high in CALC or DONE

Behaviour:
- Reset: rst_n low clears immediately, no clock needed. State = IDLE; out_valid = 0; out_product = 0; busy = 0; in_ready = 1 once rst_n is high. All internal registers = 0.
- State IDLE:
  - in_ready = 1.
  - Accept on an edge where in_valid && in_ready.
  - On accept, capture mag_a = |in_a| and mag_b = |in_b| when in_signed, else raw values. Also capture neg = in_signed && (in_a[MSB] ^ in_b[MSB]). Clear the accumulator and step count. Go to CALC.
- Most-negative operand (-2^(WIDTH-1)):
  - Its magnitude fits in WIDTH unsigned bits, so no overflow.
  - Product magnitude <= 2^(2*WIDTH-2) in signed mode and <= (2^WIDTH-1)^2 in unsigned mode. Both fit in 2*WIDTH bits with no truncation.
- State CALC, each edge:
  - If mb[0], acc += ma (2*WIDTH-bit add).
  - ma <<= 1; mb >>= 1; step++.
- CALC exit:
  - Leave on the edge where step reaches WIDTH, or, when EARLY_EXIT = 1, where the post-shift mb == 0.
  - On that edge, out_product <= neg ? -(acc_next) : acc_next, where acc_next includes that edge's add.
  - out_valid <= 1; go to DONE.
- Latency (accept edge to first edge with out_valid = 1):
  - EARLY_EXIT = 0: exactly WIDTH cycles.
  - EARLY_EXIT = 1: max(1, index of highest set bit of mag_b + 1) cycles; mag_b = 0 gives 1 cycle.
- State DONE:
  - out_valid = 1. out_product is stable until the output handshake.
  - On out_valid && out_ready: out_valid <= 0, go to IDLE.
  - in_ready = 0, so there is no same-cycle output/input overlap. Minimum initiation interval = latency + 2 cycles.
- out_product keeps its last value after the output handshake and throughout the next CALC. It changes only on CALC exit or reset.
- in_ready is 0 in CALC and DONE. Changes on in_a, in_b, in_signed or in_valid during CALC/DONE are ignored.
- Accumulator is monotonically non-decreasing during CALC. Sign is applied only at exit.
- Reset mid-CALC or mid-DONE: the result is discarded and out_valid drops immediately. No partial product is ever presented.
- No other state is reachable; encoding is implementation choice. Any illegal state returns to IDLE on the next edge.

Test Plan (WIDTH = 8):
- Unsigned 255 x 255, EARLY_EXIT = 0, out_ready = 1 -> out_valid rises 8 cycles after accept; out_product = 65025 (0xFE01); one-cycle pulse.
- Signed -128 x -128 -> 0x4000. Signed -3 x 5 -> 0xFFF1 (-15). Signed 127 x -128 -> 0xC080 (-16256). Same bit patterns unsigned: 0x80 x 0x80 -> 0x4000.
- EARLY_EXIT = 1:
  - 13 x 0 -> latency 1, product 0.
  - 200 x 3 -> latency 2, product 600 (0x0258).
  - 1 x 128 -> latency 8, product 128.
- Backpressure: out_ready low for 5 cycles after out_valid rises -> out_valid and out_product held constant, in_ready = 0, busy = 1. Raise out_ready -> handshake, then in_ready = 1 on the next cycle.
- Back-to-back: in_valid held with 6 x 7 then 9 x 9 -> products 42 then 81 in order; second accept occurs only when IDLE; out_product stays 42 during the second CALC.
- Async reset: assert rst_n low mid-CALC at step 4, between edges -> out_valid = 0, busy = 0, out_product = 0 with no clock edge. After release, a fresh 10 x 10 -> 100 with normal latency.
